instruction_sequencer: RTL and testbench

- Upstream stage of the Excutor: holds a small program of 20-bit opcodes and presents them one at a time on the Excutor's OpCode input.
- Advances only when the Excutor reports completion via Done, replacing the bench-driven opcode feed with synthesizable hardware.
- Program is written through a load port while idle, then run to completion on a Start pulse.

---
 rtl/instruction_sequencer_pkg.sv | 16 +
 rtl/instruction_sequencer_seq_prog_mem.sv | 24 ++
 rtl/instruction_sequencer.sv | 142 ++++++++++++++
 tb/tb_instruction_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// the NOP terminator opcode and the default opcode width.
package instruction_sequencer_pkg;

  localparam int OP_W_DEFAULT = 20;

  localparam logic [OP_W_DEFAULT-1:0] OP_NOP = 20'h00000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    WAIT_ACK  = 2'd2,
    HALT      = 2'd3
  } seq_state_t;

endpackage

// File: rtl/instruction_sequencer_seq_prog_mem.sv
// Program store for the instruction sequencer: register array with a
// synchronous write port and a combinational read port, contents not reset.
module seq_prog_mem #(
  parameter int OP_W  = 20,
  parameter int DEPTH = 32,
  parameter int A_W   = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [A_W-1:0]  waddr,
  input  logic [OP_W-1:0] wdata,
  input  logic [A_W-1:0]  raddr,
  output logic [OP_W-1:0] rdata
);

  logic [OP_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Feeds a stored program of opcodes to the Excutor one at a time, issuing
// the next word only after Done has been seen low (accepted) and high again.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int OP_W        = OP_W_DEFAULT,
  parameter int DEPTH       = 32,
  parameter int A_W         = 5,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            LoadEn,
  input  logic [A_W-1:0]  LoadAddr,
  input  logic [OP_W-1:0] LoadData,
  input  logic [A_W:0]    ProgLen,
  input  logic            Start,
  input  logic            ExecDone,
  output logic [OP_W-1:0] OpCode,
  output logic [A_W:0]    Pc,
  output logic [A_W:0]    IssueCount,
  output logic            Running,
  output logic            Finished,
  output logic            TimeoutErr
);

  localparam int LEN_W = A_W + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  seq_state_t       state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [LEN_W-1:0] pc_nxt, issue_nxt;
  logic [OP_W-1:0]  op_nxt;
  logic             run_nxt, fin_nxt, terr_nxt;
  logic [CNT_W-1:0] ack_cnt, ack_nxt;
  logic [OP_W-1:0]  rd_word;
  logic             mem_we;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    return (n > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : n;
  endfunction

  // The store only accepts writes while no run is in progress.
  assign mem_we = LoadEn && ((state == IDLE) || (state == HALT));

  seq_prog_mem #(
    .OP_W  (OP_W),
    .DEPTH (DEPTH),
    .A_W   (A_W)
  ) u_prog_mem (
    .clk   (Clock),
    .we    (mem_we),
    .waddr (LoadAddr),
    .wdata (LoadData),
    .raddr (Pc[A_W-1:0]),
    .rdata (rd_word)
  );

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    pc_nxt    = Pc;
    issue_nxt = IssueCount;
    op_nxt    = OpCode;
    run_nxt   = Running;
    fin_nxt   = Finished;
    terr_nxt  = TimeoutErr;
    ack_nxt   = ack_cnt;

    case (state)
      IDLE, HALT: begin
        op_nxt = '0;
        if (Start) begin
          len_nxt   = clamp_len(ProgLen);
          pc_nxt    = '0;
          issue_nxt = '0;
          fin_nxt   = 1'b0;
          terr_nxt  = 1'b0;
          run_nxt   = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // Pc == len is tested first, so the wrapped read at Pc == DEPTH is never used.
        if ((Pc == len_q) || (rd_word == OP_W'(OP_NOP))) begin
          op_nxt    = '0;
          fin_nxt   = 1'b1;
          run_nxt   = 1'b0;
          state_nxt = HALT;
        end else if (ExecDone) begin
          op_nxt    = rd_word;
          pc_nxt    = Pc + 1'b1;
          issue_nxt = IssueCount + 1'b1;
          ack_nxt   = '0;
          state_nxt = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (!ExecDone) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          terr_nxt  = 1'b1;
          op_nxt    = '0;
          fin_nxt   = 1'b0;
          run_nxt   = 1'b0;
          state_nxt = HALT;
        end else begin
          ack_nxt = ack_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      len_q      <= '0;
      Pc         <= '0;
      IssueCount <= '0;
      OpCode     <= '0;
      Running    <= 1'b0;
      Finished   <= 1'b0;
      TimeoutErr <= 1'b0;
      ack_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      len_q      <= len_nxt;
      Pc         <= pc_nxt;
      IssueCount <= issue_nxt;
      OpCode     <= op_nxt;
      Running    <= run_nxt;
      Finished   <= fin_nxt;
      TimeoutErr <= terr_nxt;
      ack_cnt    <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed and randomized programs driven
// through an Excutor Done model and compared with a program-level reference.
module tb_instruction_sequencer;

  localparam int OP_W        = 20;
  localparam int DEPTH       = 32;
  localparam int A_W         = 5;
  localparam int ACK_TIMEOUT = 8;
  localparam int BUDGET      = 3000;

  logic            Clock = 1'b0;
  logic            Reset;
  logic            LoadEn;
  logic [A_W-1:0]  LoadAddr;
  logic [OP_W-1:0] LoadData;
  logic [A_W:0]    ProgLen;
  logic            Start;
  logic            ExecDone;
  logic [OP_W-1:0] OpCode;
  logic [A_W:0]    Pc;
  logic [A_W:0]    IssueCount;
  logic            Running;
  logic            Finished;
  logic            TimeoutErr;

  int checks = 0;
  int errors = 0;

  logic [OP_W-1:0] prog [DEPTH];
  logic [OP_W-1:0] exp_q [$];
  logic [OP_W-1:0] obs_q [$];
  int first_issue;
  int end_cyc;

  instruction_sequencer #(
    .OP_W        (OP_W),
    .DEPTH       (DEPTH),
    .A_W         (A_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .LoadEn     (LoadEn),
    .LoadAddr   (LoadAddr),
    .LoadData   (LoadData),
    .ProgLen    (ProgLen),
    .Start      (Start),
    .ExecDone   (ExecDone),
    .OpCode     (OpCode),
    .Pc         (Pc),
    .IssueCount (IssueCount),
    .Running    (Running),
    .Finished   (Finished),
    .TimeoutErr (TimeoutErr)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [OP_W-1:0] data);
    LoadEn   = 1'b1;
    LoadAddr = A_W'(addr);
    LoadData = data;
    tick();
    LoadEn   = 1'b0;
    prog[addr] = data;
  endtask

  task automatic start_run(input logic [A_W:0] len);
    ExecDone = 1'b1;
    ProgLen  = len;
    Start    = 1'b1;
    tick();
    Start    = 1'b0;
  endtask

  // Reference: issue words in address order until the clamped length or the first NOP.
  task automatic build_expected(input int len);
    int lim;
    lim = (len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    for (int i = 0; i < lim; i++) begin
      if (prog[i] == '0) break;
      exp_q.push_back(prog[i]);
    end
  endtask

  // Excutor model: Done falls some cycles after each issue, rises again later.
  task automatic exec_run(input bit stuck, input bit fixed, input int load_at, input int start_at);
    int cyc, prev, fall, rise;
    cyc = 0; prev = 0; fall = 0; rise = 0;
    first_issue = -1;
    obs_q.delete();
    while (Running && cyc < BUDGET) begin
      LoadEn   = (cyc == load_at);
      LoadAddr = '0;
      LoadData = 20'hFFFFF;
      Start    = (cyc == start_at);
      if (Start) ProgLen = 6'd1;
      tick();
      cyc++;
      LoadEn = 1'b0;
      Start  = 1'b0;
      if (int'(IssueCount) != prev) begin
        prev = int'(IssueCount);
        obs_q.push_back(OpCode);
        if (first_issue < 0) first_issue = cyc;
        if (!stuck) fall = fixed ? 2 : int'($urandom_range(1, 4));
      end else if (fall > 0) begin
        fall--;
        if (fall == 0) begin
          ExecDone = 1'b0;
          rise = fixed ? 4 : int'($urandom_range(1, 6));
        end
      end else if (rise > 0) begin
        rise--;
        if (rise == 0) ExecDone = 1'b1;
      end
    end
    end_cyc = cyc;
  endtask

  task automatic check_result(input string tag);
    check({tag, ".count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, ".op"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, ".issue_count"}, 32'(IssueCount), 32'(exp_q.size()));
    check({tag, ".pc"}, 32'(Pc), 32'(exp_q.size()));
    check({tag, ".finished"}, 32'(Finished), 32'd1);
    check({tag, ".running"}, 32'(Running), 32'd0);
    check({tag, ".opcode_halt"}, 32'(OpCode), 32'd0);
    check({tag, ".timeout_err"}, 32'(TimeoutErr), 32'd0);
    if (exp_q.size() > 0) check({tag, ".first_issue_latency"}, 32'(first_issue), 32'd1);
  endtask

  initial begin
    logic [OP_W-1:0] w;
    int len;

    Reset = 1'b1; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    ProgLen = '0; Start = 1'b0; ExecDone = 1'b1;
    #7;
    check("rst.opcode", 32'(OpCode), 32'd0);
    check("rst.pc", 32'(Pc), 32'd0);
    check("rst.issue_count", 32'(IssueCount), 32'd0);
    check("rst.running", 32'(Running), 32'd0);
    check("rst.finished", 32'(Finished), 32'd0);
    check("rst.timeout_err", 32'(TimeoutErr), 32'd0);
    #1 Reset = 1'b0;
    tick();

    // Three-word program with the fixed Done timing.
    load(0, 20'h12345); load(1, 20'h0A0B0); load(2, 20'h00F01);
    build_expected(3);
    start_run(6'd3);
    check("t1.running_after_start", 32'(Running), 32'd1);
    exec_run(1'b0, 1'b1, -1, -1);
    check_result("t1");

    // NOP terminator mid-program.
    load(0, 20'h11111); load(1, 20'h00000); load(2, 20'h22222);
    build_expected(3);
    start_run(6'd3);
    exec_run(1'b0, 1'b1, -1, -1);
    check_result("t2");

    // Done stuck high after the first issue.
    load(1, 20'h33333);
    start_run(6'd3);
    exec_run(1'b1, 1'b1, -1, -1);
    check("t3.count", 32'(obs_q.size()), 32'd1);
    check("t3.op", 32'(obs_q[0]), 32'h11111);
    check("t3.timeout_cycles", 32'(end_cyc - first_issue), 32'(ACK_TIMEOUT));
    check("t3.timeout_err", 32'(TimeoutErr), 32'd1);
    check("t3.finished", 32'(Finished), 32'd0);
    check("t3.opcode", 32'(OpCode), 32'd0);
    check("t3.pc", 32'(Pc), 32'd1);
    start_run(6'd0);
    check("t3.err_cleared", 32'(TimeoutErr), 32'd0);
    tick();
    check("t3.len0_halt", 32'(Running), 32'd0);

    // Load and Start while running are ignored; a second run replays the store.
    load(0, 20'hABCDE); load(1, 20'h13579); load(2, 20'h2468A);
    build_expected(3);
    start_run(6'd3);
    exec_run(1'b0, 1'b1, 2, 4);
    check_result("t4a");
    start_run(6'd3);
    exec_run(1'b0, 1'b0, -1, -1);
    check_result("t4b");

    // Load and Start in the same cycle: the new word is issued first.
    prog[0] = 20'h5A5A5;
    LoadEn = 1'b1; LoadAddr = '0; LoadData = 20'h5A5A5;
    build_expected(3);
    ExecDone = 1'b1; ProgLen = 6'd3; Start = 1'b1;
    tick();
    LoadEn = 1'b0; Start = 1'b0;
    exec_run(1'b0, 1'b0, -1, -1);
    check_result("t5");

    // Asynchronous reset while waiting for the ack.
    load(0, 20'h12345);
    start_run(6'd2);
    tick();
    check("t6.opcode_issued", 32'(OpCode), 32'h12345);
    check("t6.issue_count", 32'(IssueCount), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("t6.rst_opcode", 32'(OpCode), 32'd0);
    check("t6.rst_running", 32'(Running), 32'd0);
    check("t6.rst_pc", 32'(Pc), 32'd0);
    check("t6.rst_issue_count", 32'(IssueCount), 32'd0);
    #2 Reset = 1'b0;
    tick();

    // Empty program.
    start_run(6'd0);
    check("t7.running", 32'(Running), 32'd1);
    tick();
    check("t7.running_end", 32'(Running), 32'd0);
    check("t7.finished", 32'(Finished), 32'd1);
    check("t7.issue_count", 32'(IssueCount), 32'd0);
    check("t7.pc", 32'(Pc), 32'd0);

    // Full store, then an over-long length that must clamp to DEPTH.
    for (int i = 0; i < DEPTH; i++) load(i, 20'($urandom_range(1, 20'hFFFFF)));
    build_expected(DEPTH);
    start_run(6'd32);
    exec_run(1'b0, 1'b0, -1, -1);
    check_result("t8");
    build_expected(40);
    start_run(6'd40);
    exec_run(1'b0, 1'b0, -1, -1);
    check_result("t8_clamp");

    // Randomized programs, lengths and Done timing.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = 20'($urandom_range(1, 20'hFFFFF));
        if ($urandom_range(0, 7) == 0) w = '0;
        load(i, w);
      end
      len = int'($urandom_range(0, 63));
      build_expected(len);
      start_run(6'(len));
      exec_run(1'b0, 1'b0, -1, -1);
      check_result("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
